sw_debounce2: RTL and testbench

- Two-channel input conditioning stage that sits directly upstream of the two-input NOR gate block.
- Takes raw, bouncy, asynchronous switch/button levels and delivers clean, synchronised levels that drive the gate's a and b inputs.
- Each channel has a 2-flop synchroniser followed by a counter-based debounce FSM.
- Both channels are identical and fully independent.

---
 rtl/sw_debounce2_if.sv | 27 ++
 rtl/sw_debounce2.sv | 123 ++++++++++++
 tb/tb_sw_debounce2.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sw_debounce2_if.sv
// sw_debounce2_if
//   Groups the switch-conditioning signals between the raw switch inputs,
//   the debounce block and the downstream NOR gate.
//   sw_a, sw_b     : raw, asynchronous switch levels
//   a, b           : debounced, registered levels
//   a_edge, b_edge : one-cycle change pulses (constant 0 unless the edge
//                    pulse build option is enabled in sw_debounce2)
//   master : drives the raw switches and observes the conditioned outputs
//   slave  : the debounce block itself
interface sw_debounce2_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
  logic a_edge;
  logic b_edge;

  modport master (
    output sw_a, sw_b,
    input  a, b, a_edge, b_edge
  );

  modport slave (
    input  sw_a, sw_b,
    output a, b, a_edge, b_edge
  );
endinterface

// File: rtl/sw_debounce2.sv
// sw_debounce2
//   Two independent switch-conditioning channels (A and B). Each channel
//   is a 2-flop synchroniser followed by a counter-based debounce FSM.
//   The output follows a new level only after that level has been seen
//   on the synchroniser output for DEBOUNCE_CYCLES consecutive clocks.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : sw_debounce2_if.slave (sw_a/sw_b in, a/b/a_edge/b_edge out)
//
//   Build option:
//     SW_DEBOUNCE2_EDGE_PULSE_EN - when defined, a_edge/b_edge pulse for one
//     cycle on the cycle a/b changes; when undefined they are tied to 0.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | synchronised input equals output, counter held at 0
//   CHECK  | synchronised input differs from output, counting stable cycles
module sw_debounce2 #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sw_debounce2_if.slave  bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_CHECK = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sw_raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       out_q;
  logic [1:0]       fire;
  logic [1:0]       edge_q;
  logic [0:0]       state_q [2];
  logic [CNT_W-1:0] cnt_q   [2];

  // Bit 0 is channel A, bit 1 is channel B throughout.
  assign sw_raw = {bus.sw_b, bus.sw_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // fire marks the cycle on which a channel's output is about to flip:
  // the new level has now been stable for the full debounce window.
  always_comb begin
    fire = '0;
    for (int ch = 0; ch < 2; ch++) begin
      fire[ch] = (state_q[ch] == ST_CHECK) && (s2[ch] != out_q[ch]) &&
                 (cnt_q[ch] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= ST_IDLE;
        cnt_q[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        case (state_q[ch])
          ST_IDLE: begin
            if (s2[ch] != out_q[ch]) begin
              state_q[ch] <= ST_CHECK;
              cnt_q[ch]   <= CNT_W'(1);
            end else begin
              cnt_q[ch]   <= '0;
            end
          end
          ST_CHECK: begin
            if (s2[ch] == out_q[ch]) begin
              // Bounced back before the window closed: discard the attempt.
              state_q[ch] <= ST_IDLE;
              cnt_q[ch]   <= '0;
            end else if (fire[ch]) begin
              out_q[ch]   <= s2[ch];
              state_q[ch] <= ST_IDLE;
              cnt_q[ch]   <= '0;
            end else begin
              cnt_q[ch]   <= cnt_q[ch] + CNT_W'(1);
            end
          end
          default: begin
            state_q[ch] <= ST_IDLE;
            cnt_q[ch]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SW_DEBOUNCE2_EDGE_PULSE_EN
  // Registered alongside out_q so the pulse lines up with the output change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= fire;
    end
  end
`else
  assign edge_q = '0;
`endif

  assign bus.a      = out_q[0];
  assign bus.b      = out_q[1];
  assign bus.a_edge = edge_q[0];
  assign bus.b_edge = edge_q[1];

endmodule

// File: tb/tb_sw_debounce2.sv
module tb_sw_debounce2;

  localparam int DC = 4;

`ifdef SW_DEBOUNCE2_EDGE_PULSE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  sw_debounce2_if bus ();

  sw_debounce2 #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.sw_a   = 1'b0;
    bus.sw_b   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic exp;
    step();
    rst_n    = 1'b0;
    bus.sw_a = 1'b1;
    bus.sw_b = 1'b1;
    #1;
    n_vec++;
    if ({bus.a, bus.b, bus.a_edge, bus.b_edge} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_async got %b required 0000",
               {bus.a, bus.b, bus.a_edge, bus.b_edge});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      n_vec++;
      if ({bus.a, bus.b, bus.a_edge, bus.b_edge} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got %b required 0000", i,
                 {bus.a, bus.b, bus.a_edge, bus.b_edge});
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      exp = (k >= DC + 1);
      n_vec++;
      if (bus.a !== exp || bus.b !== exp) begin
        n_err++;
        $display("FAIL reset_release k=%0d got a=%b b=%b required %b",
                 k, bus.a, bus.b, exp);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && k == DC + 1) ||
          bus.b_edge !== (EDGE_EN && k == DC + 1)) begin
        n_err++;
        $display("FAIL reset_release_edge k=%0d got %b%b required %b",
                 k, bus.a_edge, bus.b_edge, EDGE_EN && k == DC + 1);
      end
    end
  endtask

  task automatic test_clean_step();
    do_reset();
    bus.sw_a = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_vec++;
      if (bus.a !== (k >= 5) || bus.b !== 1'b0) begin
        n_err++;
        $display("FAIL clean_rise k=%0d got a=%b b=%b required a=%b b=0",
                 k, bus.a, bus.b, k >= 5);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && k == 5) || bus.b_edge !== 1'b0) begin
        n_err++;
        $display("FAIL clean_rise_edge k=%0d got %b required %b",
                 k, bus.a_edge, EDGE_EN && k == 5);
      end
    end
    bus.sw_a = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_vec++;
      if (bus.a !== (k < 5)) begin
        n_err++;
        $display("FAIL clean_fall k=%0d got %b required %b", k, bus.a, k < 5);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && k == 5)) begin
        n_err++;
        $display("FAIL clean_fall_edge k=%0d got %b required %b",
                 k, bus.a_edge, EDGE_EN && k == 5);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.sw_b = (i < 8) ? (((i / 2) % 2) == 0) : 1'b0;
      step();
      n_vec++;
      if (bus.b !== 1'b0 || bus.b_edge !== 1'b0) begin
        n_err++;
        $display("FAIL bounce i=%0d got b=%b b_edge=%b required 0 0",
                 i, bus.b, bus.b_edge);
      end
    end
  endtask

  task automatic test_near_miss();
    logic exp;
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      bus.sw_a = (k < 3);
      step();
      n_vec++;
      if (bus.a !== 1'b0 || bus.a_edge !== 1'b0) begin
        n_err++;
        $display("FAIL near_miss3 k=%0d got a=%b a_edge=%b required 0 0",
                 k, bus.a, bus.a_edge);
      end
    end
    for (int k = 0; k <= 12; k++) begin
      bus.sw_a = (k < 4);
      step();
      exp = (k >= 5 && k <= 8);
      n_vec++;
      if (bus.a !== exp) begin
        n_err++;
        $display("FAIL near_miss4 k=%0d got %b required %b", k, bus.a, exp);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && (k == 5 || k == 9))) begin
        n_err++;
        $display("FAIL near_miss4_edge k=%0d got %b required %b",
                 k, bus.a_edge, EDGE_EN && (k == 5 || k == 9));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.sw_a = 1'b1;
    bus.sw_b = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_vec++;
      if (bus.a !== (k >= 5) || bus.b !== (k >= 5)) begin
        n_err++;
        $display("FAIL simul k=%0d got a=%b b=%b required %b",
                 k, bus.a, bus.b, k >= 5);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && k == 5) ||
          bus.b_edge !== (EDGE_EN && k == 5)) begin
        n_err++;
        $display("FAIL simul_edge k=%0d got %b%b required %b",
                 k, bus.a_edge, bus.b_edge, EDGE_EN && k == 5);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    bus.sw_a = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.a !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_assert got %b required 0", bus.a);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      n_vec++;
      if (bus.a !== (k >= 5)) begin
        n_err++;
        $display("FAIL mid_reset k=%0d got %b required %b", k, bus.a, k >= 5);
      end
      n_vec++;
      if (bus.a_edge !== (EDGE_EN && k == 5)) begin
        n_err++;
        $display("FAIL mid_reset_edge k=%0d got %b required %b",
                 k, bus.a_edge, EDGE_EN && k == 5);
      end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.sw_a = 1'b0;
    bus.sw_b = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_near_miss();
    test_simultaneous();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
